// File: rtl/mem_dma_master_pkg.sv
// Shared constants for the main-memory DMA initiator: operation codes and FSM state encoding.
package mem_dma_master_pkg;

  localparam logic DMA_OP_COPY = 1'b0;
  localparam logic DMA_OP_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/mem_dma_master.sv
// Block COPY/FILL initiator for the single-port main memory (async read, sync write).
// Owns the memory port while busy; all port outputs decode from registered state only.
module mem_dma_master
  import mem_dma_master_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  dma_state_e        state_q;
  dma_state_e        state_d;
  logic              op_q;
  logic [ADDR_W-1:0] src_ptr_q;
  logic [ADDR_W-1:0] dst_ptr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] buf_q;
  logic              accept;

  // FIN behaves like IDLE for a new request so transfers can run back-to-back.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_FIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (accept) begin
          if (len == '0) begin
            state_d = ST_FIN;
          end else if (op == DMA_OP_FILL) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        state_d = ST_WR;
      end
      ST_WR: begin
        if (remaining_q == LEN_ONE) begin
          state_d = ST_FIN;
        end else if (op_q == DMA_OP_FILL) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointers wrap silently at 2**ADDR_W; copies walk strictly upward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= DMA_OP_COPY;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      fill_q      <= '0;
      buf_q       <= '0;
    end else begin
      if (accept) begin
        op_q        <= op;
        src_ptr_q   <= src_addr;
        dst_ptr_q   <= dst_addr;
        remaining_q <= len;
        fill_q      <= fill_val;
      end else if (state_q == ST_RD) begin
        buf_q <= mem_rdata;
      end else if (state_q == ST_WR) begin
        src_ptr_q   <= src_ptr_q + ADDR_ONE;
        dst_ptr_q   <= dst_ptr_q + ADDR_ONE;
        remaining_q <= remaining_q - LEN_ONE;
      end
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_w_en  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_RD: begin
        busy     = 1'b1;
        mem_addr = src_ptr_q;
      end
      ST_WR: begin
        busy      = 1'b1;
        mem_w_en  = 1'b1;
        mem_addr  = dst_ptr_q;
        mem_wdata = (op_q == DMA_OP_FILL) ? fill_q : buf_q;
      end
      ST_FIN: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dma_master.sv
// Self-checking bench for mem_dma_master: memory responder plus a word-level reference copy/fill model.
module tb_mem_dma_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [9:0]  len;
  logic [15:0] fill_val;
  logic        busy;
  logic        done;
  logic        mem_w_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic        tb_we;
  logic [9:0]  tb_waddr;
  logic [15:0] tb_wdata;

  int checks;
  int failures;

  mem_dma_master #(.ADDR_W(10), .DATA_W(16), .LEN_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_val  (fill_val),
    .busy      (busy),
    .done      (done),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: combinational read, write on the rising edge; bench preload port when DUT idle.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_w_en) begin
      mem[mem_addr] <= mem_wdata;
    end else if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tb_write(input logic [9:0] a, input logic [15:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic int mem_diffs();
    int n;
    n = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) n++;
    end
    return n;
  endfunction

  // Runs one transfer from the cycle where start is driven; returns at the done cycle when chaining.
  task automatic applyStimulus(input string tag, input logic op_i, input logic [9:0] src_i,
                               input logic [9:0] dst_i, input logic [9:0] len_i,
                               input logic [15:0] fill_i, input bit noise, input bit chain);
    int k, lat, busy_cnt, wr_cnt, rd_cnt, bad_addr, exp_lat, budget;
    bit got_done;
    for (int i = 0; i < int'(len_i); i++) begin
      int s;
      int d;
      s = (int'(src_i) + i) % 1024;
      d = (int'(dst_i) + i) % 1024;
      ref_mem[d] = (op_i == 1'b1) ? fill_i : ref_mem[s];
    end
    if (len_i == 10'd0) exp_lat = 0;
    else if (op_i == 1'b1) exp_lat = int'(len_i);
    else exp_lat = 2 * int'(len_i);
    start = 1'b1; op = op_i; src_addr = src_i; dst_addr = dst_i; len = len_i; fill_val = fill_i;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0; lat = -1; busy_cnt = 0; wr_cnt = 0; rd_cnt = 0; bad_addr = 0; got_done = 0;
    budget = 2 * int'(len_i) + 8;
    while (!got_done && k <= budget) begin
      if (noise && k == 1) begin
        start = 1'b1; op = ~op_i; src_addr = 10'($urandom_range(1023, 0));
        dst_addr = 10'($urandom_range(1023, 0)); len = 10'd7; fill_val = 16'hDEAD;
      end
      if (noise && k == 3) start = 1'b0;
      if (done) begin
        got_done = 1;
        lat = k;
        if (busy || mem_w_en) bad_addr++;
      end else begin
        if (busy) busy_cnt++;
        if (busy && !mem_w_en) begin
          if (int'(mem_addr) != (int'(src_i) + rd_cnt) % 1024) bad_addr++;
          rd_cnt++;
        end
        if (mem_w_en) begin
          if (int'(mem_addr) != (int'(dst_i) + wr_cnt) % 1024) bad_addr++;
          wr_cnt++;
        end
        @(posedge clk);
        #1;
        k++;
      end
    end
    checkOutput({tag, " done_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    checkOutput({tag, " write_count"}, 32'(wr_cnt), 32'(len_i));
    checkOutput({tag, " read_count"}, 32'(rd_cnt), (op_i == 1'b1) ? 32'd0 : 32'(len_i));
    checkOutput({tag, " addr_seq_errors"}, 32'(bad_addr), 32'd0);
    checkOutput({tag, " mem_diffs"}, 32'(mem_diffs()), 32'd0);
    if (!chain) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
      checkOutput({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int mask;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    #2;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset w_en", {31'd0, mem_w_en}, 32'd0);
    checkOutput("reset addr", {22'd0, mem_addr}, 32'd0);
    checkOutput("reset wdata", {16'd0, mem_wdata}, 32'd0);
    for (int i = 0; i < 1024; i++) tb_write(10'(i), 16'($urandom));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] fill len=4");
    applyStimulus("fill4", 1'b1, 10'h000, 10'h010, 10'd4, 16'hBEEF, 0, 0);
    checkOutput("fill4 word0", {16'd0, mem[10'h010]}, 32'hBEEF);
    checkOutput("fill4 word3", {16'd0, mem[10'h013]}, 32'hBEEF);
    checkOutput("fill4 untouched", {16'd0, mem[10'h014]}, {16'd0, ref_mem[10'h014]});

    $display("[TB] copy len=3 with write-enable pattern");
    tb_write(10'h000, 16'd1);
    tb_write(10'h001, 16'd2);
    tb_write(10'h002, 16'd3);
    start = 1'b1; op = 1'b0; src_addr = 10'h000; dst_addr = 10'h100; len = 10'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    mask = 0;
    for (int c = 0; c < 7; c++) begin
      if (mem_w_en) mask |= (1 << c);
      if (c < 6) begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("copy3 wen_mask", 32'(mask), 32'h2A);
    checkOutput("copy3 done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) ref_mem[10'h100 + i] = ref_mem[i];
    checkOutput("copy3 word0", {16'd0, mem[10'h100]}, 32'd1);
    checkOutput("copy3 word2", {16'd0, mem[10'h102]}, 32'd3);
    checkOutput("copy3 mem_diffs", 32'(mem_diffs()), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] copy across address wrap");
    applyStimulus("wrap", 1'b0, 10'h3FF, 10'h200, 10'd2, 16'h0000, 0, 0);
    checkOutput("wrap word0", {16'd0, mem[10'h200]}, {16'd0, mem[10'h3FF]});
    checkOutput("wrap word1", {16'd0, mem[10'h201]}, {16'd0, mem[10'h000]});

    $display("[TB] zero-length requests");
    applyStimulus("len0copy", 1'b0, 10'h050, 10'h060, 10'd0, 16'h0000, 0, 0);
    applyStimulus("len0fill", 1'b1, 10'h050, 10'h060, 10'd0, 16'h1234, 0, 0);

    $display("[TB] start ignored while busy, then back-to-back");
    applyStimulus("noise", 1'b0, 10'h020, 10'h140, 10'd3, 16'h0000, 1, 0);
    applyStimulus("chainA", 1'b0, 10'h030, 10'h150, 10'd3, 16'h0000, 0, 1);
    applyStimulus("chainB", 1'b1, 10'h000, 10'h160, 10'd2, 16'hA5A5, 0, 0);

    $display("[TB] overlapping copy and random transfers");
    applyStimulus("overlap", 1'b0, 10'h080, 10'h082, 10'd6, 16'h0000, 0, 0);
    for (int r = 0; r < 6; r++) begin
      applyStimulus($sformatf("rand%0d", r), 1'($urandom_range(1, 0)),
                    10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)),
                    10'($urandom_range(40, 1)), 16'($urandom), 0, 0);
    end

    $display("[TB] reset during a write");
    start = 1'b1; op = 1'b0; src_addr = 10'h040; dst_addr = 10'h300; len = 10'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrst w_en_before", {31'd0, mem_w_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst w_en", {31'd0, mem_w_en}, 32'd0);
    checkOutput("midrst addr", {22'd0, mem_addr}, 32'd0);
    for (int i = 0; i < 2; i++) ref_mem[10'h300 + i] = ref_mem[10'h040 + i];
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst done", {31'd0, done}, 32'd0);
    checkOutput("postrst busy", {31'd0, busy}, 32'd0);
    checkOutput("postrst mem_diffs", 32'(mem_diffs()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
